// File: rtl/count_step_monitor_if.sv
// Sample input and event output stream of the counter step monitor.
// The monitor uses the master side; the observer/consumer uses the slave side.
interface count_step_monitor_if;
  logic        sample_en;
  logic [31:0] cnt_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_code;
  logic [31:0] evt_value;

  modport master (
    input  sample_en, cnt_in, evt_ready,
    output evt_valid, evt_code, evt_value
  );

  modport slave (
    output sample_en, cnt_in, evt_ready,
    input  evt_valid, evt_code, evt_value
  );
endinterface

// File: rtl/count_step_monitor.sv
// Classifies successive samples of a 32-bit up/down counter into step events,
// queues them in a small valid/ready FIFO and keeps saturating wrap/jump stats.
module count_step_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  count_step_monitor_if.master  bus,
  output logic [STAT_W-1:0]     up_wraps,
  output logic [STAT_W-1:0]     dn_wraps,
  output logic [STAT_W-1:0]     jumps,
  output logic                  ovf,
  output logic                  tracking
);

  localparam int DATA_W = 32;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  localparam logic [2:0] EV_NONE    = 3'd0;
  localparam logic [2:0] EV_UP      = 3'd1;
  localparam logic [2:0] EV_DOWN    = 3'd2;
  localparam logic [2:0] EV_WRAP_UP = 3'd3;
  localparam logic [2:0] EV_WRAP_DN = 3'd4;
  localparam logic [2:0] EV_JUMP    = 3'd5;

  typedef enum logic {IDLE, TRACK} state_t;

  state_t              state;
  logic [DATA_W-1:0]   prev_p0;
  logic [2:0]          code_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0]   value_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;

  logic [2:0]          cls_code;
  logic                sample_hit;
  logic                push;
  logic                pop;
  logic                full;
  logic                push_ok;

  // HOLD maps to EV_NONE so it never reaches the queue.
  function automatic logic [2:0] classify(input logic [DATA_W-1:0] prev,
                                          input logic [DATA_W-1:0] cur);
    if (&prev && cur == '0)          return EV_WRAP_UP;
    else if (prev == '0 && &cur)     return EV_WRAP_DN;
    else if (cur == prev)            return EV_NONE;
    else if (cur == prev + 32'd1)    return EV_UP;
    else if (cur == prev - 32'd1)    return EV_DOWN;
    else                             return EV_JUMP;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    cls_code   = classify(prev_p0, bus.cnt_in);
    sample_hit = bus.sample_en && (state == TRACK);
    push       = sample_hit && (cls_code != EV_NONE);
    full       = (count == DEPTH_C);
    pop        = (count != '0) && bus.evt_ready;
    push_ok    = push && (!full || pop);
  end

  // Head of queue is presented directly; empty queue reads as all zero.
  assign bus.evt_valid = (count != '0);
  assign bus.evt_code  = bus.evt_valid ? code_mem[rd_ptr]  : EV_NONE;
  assign bus.evt_value = bus.evt_valid ? value_mem[rd_ptr] : '0;

  // Data path: baseline and queue storage carry no reset, occupancy gates them.
  always_ff @(posedge clk) begin
    if (bus.sample_en)
      prev_p0 <= bus.cnt_in;
    if (push_ok) begin
      code_mem[wr_ptr]  <= cls_code;
      value_mem[wr_ptr] <= bus.cnt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state    <= IDLE;
      tracking <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      up_wraps <= '0;
      dn_wraps <= '0;
      jumps    <= '0;
    end else begin
      if (bus.sample_en && state == IDLE) begin
        state    <= TRACK;
        tracking <= 1'b1;
      end

      if (sample_hit) begin
        case (cls_code)
          EV_WRAP_UP: up_wraps <= sat_inc(up_wraps);
          EV_WRAP_DN: dn_wraps <= sat_inc(dn_wraps);
          EV_JUMP:    jumps    <= sat_inc(jumps);
          default: ;
        endcase
      end

      if (push && full && !pop)
        ovf <= 1'b1;

      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_count_step_monitor.sv
// Directed bench for count_step_monitor: step classification, queue ordering,
// overflow, clear behaviour and statistic saturation.
module tb_count_step_monitor;
  logic clk = 1'b0;
  logic rst;
  logic clr;

  logic [15:0] up_wraps, dn_wraps, jumps;
  logic        ovf, tracking;
  logic [1:0]  up_wraps2, dn_wraps2, jumps2;
  logic        ovf2, tracking2;

  int tests = 0;
  int fails = 0;

  count_step_monitor_if bus  ();
  count_step_monitor_if bus2 ();

  count_step_monitor #(.FIFO_DEPTH(4), .STAT_W(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus),
    .up_wraps (up_wraps),
    .dn_wraps (dn_wraps),
    .jumps    (jumps),
    .ovf      (ovf),
    .tracking (tracking)
  );

  count_step_monitor #(.FIFO_DEPTH(4), .STAT_W(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus2),
    .up_wraps (up_wraps2),
    .dn_wraps (dn_wraps2),
    .jumps    (jumps2),
    .ovf      (ovf2),
    .tracking (tracking2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] v);
    bus.sample_en  = 1'b1;
    bus.cnt_in     = v;
    bus2.sample_en = 1'b1;
    bus2.cnt_in    = v;
    tick();
    bus.sample_en  = 1'b0;
    bus2.sample_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [2:0] code, input logic [31:0] val);
    chk({tag, "_valid"}, bus.evt_valid, 1'b1);
    chk({tag, "_code"},  bus.evt_code,  code);
    chk({tag, "_value"}, bus.evt_value, val);
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.sample_en  = 1'b0;
    bus.cnt_in     = '0;
    bus.evt_ready  = 1'b0;
    bus2.sample_en = 1'b0;
    bus2.cnt_in    = '0;
    bus2.evt_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid",    bus.evt_valid, 1'b0);
    chk("rst_code",     bus.evt_code,  3'd0);
    chk("rst_value",    bus.evt_value, 32'd0);
    chk("rst_stats",    {up_wraps, dn_wraps, jumps}, 48'd0);
    chk("rst_ovf",      ovf,      1'b0);
    chk("rst_tracking", tracking, 1'b0);

    // T1: baseline then two up steps
    sample(32'd5);
    chk("t1_tracking", tracking,      1'b1);
    chk("t1_base_nev", bus.evt_valid, 1'b0);
    sample(32'd6);
    sample(32'd7);
    pop_expect("t1_up6", 3'd1, 32'd6);
    pop_expect("t1_up7", 3'd1, 32'd7);
    chk("t1_empty", bus.evt_valid, 1'b0);

    // T2: wrap in both directions
    do_clr();
    sample(32'hFFFF_FFFE);
    sample(32'hFFFF_FFFF);
    sample(32'h0000_0000);
    sample(32'hFFFF_FFFF);
    pop_expect("t2_up",   3'd1, 32'hFFFF_FFFF);
    pop_expect("t2_wrup", 3'd3, 32'h0000_0000);
    pop_expect("t2_wrdn", 3'd4, 32'hFFFF_FFFF);
    chk("t2_up_wraps", up_wraps, 16'd1);
    chk("t2_dn_wraps", dn_wraps, 16'd1);
    chk("t2_jumps",    jumps,    16'd0);

    // T3: hold then jump, head stable while stalled
    do_clr();
    sample(32'd10);
    sample(32'd10);
    chk("t3_hold_nev", bus.evt_valid, 1'b0);
    sample(32'd3);
    tick();
    tick();
    chk("t3_stall_code",  bus.evt_code,  3'd5);
    chk("t3_stall_value", bus.evt_value, 32'd3);
    pop_expect("t3_jump", 3'd5, 32'd3);
    chk("t3_jumps", jumps, 16'd1);
    chk("t3_empty", bus.evt_valid, 1'b0);

    // T4: overflow with consumer stalled
    do_clr();
    sample(32'd100);
    for (int i = 1; i <= 4; i++) sample(32'd100 + i);
    chk("t4_ovf_at_full", ovf, 1'b0);
    sample(32'd105);
    sample(32'd106);
    chk("t4_ovf", ovf, 1'b1);
    for (int i = 1; i <= 4; i++) pop_expect("t4_drain", 3'd1, 32'd100 + i);
    chk("t4_empty",       bus.evt_valid, 1'b0);
    chk("t4_empty_code",  bus.evt_code,  3'd0);
    chk("t4_empty_value", bus.evt_value, 32'd0);
    chk("t4_ovf_sticky",  ovf, 1'b1);

    // T5: push and pop together on a full queue
    do_clr();
    chk("t5_ovf_cleared", ovf, 1'b0);
    sample(32'd200);
    for (int i = 1; i <= 4; i++) sample(32'd200 + i);
    bus.evt_ready = 1'b1;
    sample(32'd205);
    bus.evt_ready = 1'b0;
    chk("t5_ovf", ovf, 1'b0);
    for (int i = 2; i <= 5; i++) pop_expect("t5_drain", 3'd1, 32'd200 + i);
    chk("t5_empty", bus.evt_valid, 1'b0);

    // T6: clear while events are queued, sample in the clear cycle ignored
    do_clr();
    sample(32'd300);
    sample(32'd500);
    sample(32'd501);
    chk("t6_jumps_pre", jumps, 16'd1);
    clr = 1'b1;
    sample(32'd303);
    clr = 1'b0;
    chk("t6_valid",    bus.evt_valid, 1'b0);
    chk("t6_stats",    {up_wraps, dn_wraps, jumps}, 48'd0);
    chk("t6_tracking", tracking, 1'b0);
    sample(32'd600);
    chk("t6_base_nev",  bus.evt_valid, 1'b0);
    chk("t6_tracking2", tracking, 1'b1);
    sample(32'd601);
    pop_expect("t6_up", 3'd1, 32'd601);

    // T7: statistic saturation on the narrow-stat instance
    do_clr();
    sample(32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      sample(32'h0000_0000);
      if (i < 4) sample(32'hFFFF_FFFF);
    end
    chk("t7_up_wraps_sat", up_wraps2, 2'd3);
    chk("t7_dn_wraps_sat", dn_wraps2, 2'd3);
    chk("t7_up_wraps_wide", up_wraps, 16'd5);
    chk("t7_dn_wraps_wide", dn_wraps, 16'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
